register_file_sb: RTL

REGISTER_FILE_SB -- requirements
Module: register_file_sb

---
 rtl/regfile_pkg.sv | 7 +
 rtl/regfile_scoreboard.sv | 54 +++++
 rtl/register_file_sb.sv | 84 ++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry and the
// address of the optionally hardwired zero register.
package regfile_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int ZERO_ADDR  = 0;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write scoreboard: one busy bit per register plus a registered count of
// busy registers. A reservation and a write to the same register leave it busy.
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      ld_i,
    input  logic [ADDR_W-1:0]         dr_i,
    input  logic                      rsv_i,
    input  logic [ADDR_W-1:0]         rsv_addr_i,
    output logic [(1<<ADDR_W)-1:0]    busy_o,
    output logic [ADDR_W:0]           busy_cnt_o
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DEPTH-1:0] busy_q;
    logic [DEPTH-1:0] busy_d;
    logic [ADDR_W:0]  cnt_q;
    logic [ADDR_W:0]  cnt_d;
    logic             rsv_eff;
    logic             inc;
    logic             dec;

    assign rsv_eff = rsv_i && !((ZERO_REG != 0) && (rsv_addr_i == ADDR_W'(ZERO_ADDR)));

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            assign busy_d[gi] = (rsv_eff && (rsv_addr_i == ADDR_W'(gi)))
                              || (busy_q[gi] && !(ld_i && (dr_i == ADDR_W'(gi))));
        end
    endgenerate

    // Count tracks transitions only, so it cannot drift from the busy bits.
    assign inc   = rsv_eff && !busy_q[rsv_addr_i];
    assign dec   = ld_i && busy_q[dr_i] && !(rsv_eff && (rsv_addr_i == dr_i));
    assign cnt_d = cnt_q + {{ADDR_W{1'b0}}, inc} - {{ADDR_W{1'b0}}, dec};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy_o     = busy_q;
    assign busy_cnt_o = cnt_q;
endmodule

// File: rtl/register_file_sb.sv
// Two-read/one-write register file with pending-write scoreboard.
// Optional feature: define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module register_file_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              LD,
    input  logic [ADDR_W-1:0] DR,
    input  logic [DATA_W-1:0] D_IN,
    input  logic [ADDR_W-1:0] SA,
    input  logic [ADDR_W-1:0] SB,
    output logic [DATA_W-1:0] DATA_A,
    output logic [DATA_W-1:0] DATA_B,
    input  logic              RSV,
    input  logic [ADDR_W-1:0] RSV_ADDR,
    output logic              BUSY_A,
    output logic              BUSY_B,
    output logic [ADDR_W:0]   BUSY_CNT
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]  busy;
    logic [DATA_W-1:0] stored_a;
    logic [DATA_W-1:0] stored_b;
    logic              zero_a;
    logic              zero_b;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
            logic we;
            assign we = LD && (DR == ADDR_W'(gi)) && !((ZERO_REG != 0) && (gi == ZERO_ADDR));
            always_ff @(posedge CLK or posedge RST) begin
                if (RST) begin
                    regs_q[gi] <= '0;
                end else if (we) begin
                    regs_q[gi] <= D_IN;
                end
            end
        end
    endgenerate

    regfile_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk_i      (CLK),
        .rst_i      (RST),
        .ld_i       (LD),
        .dr_i       (DR),
        .rsv_i      (RSV),
        .rsv_addr_i (RSV_ADDR),
        .busy_o     (busy),
        .busy_cnt_o (BUSY_CNT)
    );

    assign zero_a   = (ZERO_REG != 0) && (SA == ADDR_W'(ZERO_ADDR));
    assign zero_b   = (ZERO_REG != 0) && (SB == ADDR_W'(ZERO_ADDR));
    assign stored_a = zero_a ? '0 : regs_q[SA];
    assign stored_b = zero_b ? '0 : regs_q[SB];

`ifdef REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    // A write in flight satisfies the reader now, so the operand is no longer pending.
    assign byp_a  = LD && (DR == SA) && !zero_a;
    assign byp_b  = LD && (DR == SB) && !zero_b;
    assign DATA_A = byp_a ? D_IN : stored_a;
    assign DATA_B = byp_b ? D_IN : stored_b;
    assign BUSY_A = busy[SA] && !byp_a;
    assign BUSY_B = busy[SB] && !byp_b;
`else
    assign DATA_A = stored_a;
    assign DATA_B = stored_b;
    assign BUSY_A = busy[SA];
    assign BUSY_B = busy[SB];
`endif
endmodule
